// File: rtl/abz_home_ctrl.sv
// Homing sequencer and velocity sampler for the ABZ quadrature detector.
// Optional seek retry is enabled by defining ABZ_HOME_RETRY_EN.
module abz_home_ctrl #(
  parameter int unsigned              BIT_LENGTH    = 12,
  parameter int unsigned              TMO_WIDTH     = 24,
  parameter logic [TMO_WIDTH-1:0]     SEEK_TIMEOUT  = 24'd1000000,
  parameter int unsigned              SETTLE_CYCLES = 6,
  parameter int unsigned              SAMPLE_PERIOD = 1000,
  parameter int unsigned              MAX_RETRY     = 3
) (
  input  logic                  CLK,
  input  logic                  ARSTN,
  input  logic                  START_IN,
  input  logic                  ABORT_IN,
  input  logic                  Z_IN,
  input  logic [BIT_LENGTH-1:0] CFG_INIT_COUNT,
  input  logic [BIT_LENGTH-1:0] LATCHED_CNT_IN,
  output logic                  EN_INIT_OUT,
  output logic [BIT_LENGTH-1:0] INIT_COUNT_OUT,
  output logic                  EN_OUTPUT_OUT,
  output logic [BIT_LENGTH-1:0] VEL_OUT,
  output logic                  VEL_VALID,
  output logic                  HOMED,
  output logic                  BUSY,
  output logic                  FAULT_OUT
);

  localparam int unsigned StW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned SpW = $clog2(SAMPLE_PERIOD);
  localparam logic [TMO_WIDTH-1:0] TmoLast    = SEEK_TIMEOUT - TMO_WIDTH'(1);
  localparam logic [StW-1:0]       SettleLast = StW'(SETTLE_CYCLES - 1);
  localparam logic [SpW-1:0]       SampLast   = SpW'(SAMPLE_PERIOD - 1);

  typedef enum logic [2:0] {StIdle, StInit, StSeek, StSettle, StRun, StFault} state_e;

  state_e                state_q, state_d;
  logic                  start_q;
  logic                  z_s1_q, z_s2_q, z_d_q;
  logic                  z_rise, start_rise, enter_init, run_stay;
  logic                  init_ph_q, init_ph_d;
  logic [TMO_WIDTH-1:0]  tmo_q, tmo_d;
  logic [StW-1:0]        settle_q, settle_d;
  logic [SpW-1:0]        samp_q, samp_d;
  logic                  en_init_q, en_init_d;
  logic                  en_out_q, en_out_d;
  logic [BIT_LENGTH-1:0] init_cnt_q, init_cnt_d;
  logic                  cap_pend_q, cap_pend_d;
  logic                  seeded_q, seeded_d;
  logic [BIT_LENGTH-1:0] prev_q, prev_d;
  logic [BIT_LENGTH-1:0] vel_q, vel_d;
  logic                  vel_valid_q, vel_valid_d;
  logic                  homed_q, busy_q, fault_q;

`ifdef ABZ_HOME_RETRY_EN
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry_q, retry_d;
`endif

  assign z_rise     = z_s2_q & ~z_d_q;
  assign start_rise = START_IN & ~start_q;

  always_comb begin
    state_d     = state_q;
    init_ph_d   = init_ph_q;
    tmo_d       = tmo_q;
    settle_d    = settle_q;
    samp_d      = samp_q;
    en_init_d   = en_init_q;
    en_out_d    = 1'b0;
    init_cnt_d  = init_cnt_q;
    enter_init  = 1'b0;
`ifdef ABZ_HOME_RETRY_EN
    retry_d     = retry_q;
    if (state_q == StIdle) retry_d = '0;
`endif

    if (ABORT_IN) begin
      state_d   = StIdle;
      en_init_d = 1'b0;
`ifdef ABZ_HOME_RETRY_EN
      retry_d   = '0;
`endif
    end else if (start_rise) begin
      enter_init = 1'b1;
`ifdef ABZ_HOME_RETRY_EN
      retry_d    = '0;
`endif
    end else begin
      case (state_q)
        StIdle: ;
        StInit: begin
          // Two-cycle init enable: phase 0 then phase 1, then hand over to SEEK.
          if (init_ph_q) begin
            state_d   = StSeek;
            en_init_d = 1'b0;
            tmo_d     = '0;
          end else begin
            init_ph_d = 1'b1;
          end
        end
        StSeek: begin
          if (z_rise) begin
            state_d  = StSettle;
            settle_d = '0;
          end else if (tmo_q == TmoLast) begin
`ifdef ABZ_HOME_RETRY_EN
            if (retry_q < RW'(MAX_RETRY - 1)) begin
              retry_d    = retry_q + RW'(1);
              enter_init = 1'b1;
            end else begin
              state_d = StFault;
            end
`else
            state_d = StFault;
`endif
          end else begin
            tmo_d = tmo_q + TMO_WIDTH'(1);
          end
        end
        StSettle: begin
          if (settle_q == SettleLast) begin
            state_d = StRun;
            samp_d  = '0;
          end else begin
            settle_d = settle_q + StW'(1);
          end
        end
        StRun: begin
          if (samp_q == SampLast) begin
            samp_d   = '0;
            en_out_d = 1'b1;
          end else begin
            samp_d = samp_q + SpW'(1);
          end
        end
        StFault: ;
        default: state_d = StIdle;
      endcase
    end

    if (enter_init) begin
      state_d    = StInit;
      init_ph_d  = 1'b0;
      en_init_d  = 1'b1;
      init_cnt_d = CFG_INIT_COUNT;
      tmo_d      = '0;
    end
  end

  // Velocity pipeline: strobe in t, capture at end of t+1, valid in t+2.
  assign run_stay = (state_q == StRun) && (state_d == StRun);

  always_comb begin
    cap_pend_d  = en_out_q & run_stay;
    seeded_d    = seeded_q;
    prev_d      = prev_q;
    vel_d       = vel_q;
    vel_valid_d = 1'b0;
    if (!run_stay) begin
      seeded_d = 1'b0;
    end else if (cap_pend_q) begin
      prev_d   = LATCHED_CNT_IN;
      seeded_d = 1'b1;
      if (seeded_q) begin
        vel_d       = LATCHED_CNT_IN - prev_q;
        vel_valid_d = 1'b1;
      end
    end
    if (state_d == StIdle) vel_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (!ARSTN) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      z_s1_q      <= 1'b0;
      z_s2_q      <= 1'b0;
      z_d_q       <= 1'b0;
      init_ph_q   <= 1'b0;
      tmo_q       <= '0;
      settle_q    <= '0;
      samp_q      <= '0;
      en_init_q   <= 1'b0;
      en_out_q    <= 1'b0;
      init_cnt_q  <= '0;
      cap_pend_q  <= 1'b0;
      seeded_q    <= 1'b0;
      prev_q      <= '0;
      vel_q       <= '0;
      vel_valid_q <= 1'b0;
      homed_q     <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= START_IN;
      z_s1_q      <= Z_IN;
      z_s2_q      <= z_s1_q;
      z_d_q       <= z_s2_q;
      init_ph_q   <= init_ph_d;
      tmo_q       <= tmo_d;
      settle_q    <= settle_d;
      samp_q      <= samp_d;
      en_init_q   <= en_init_d;
      en_out_q    <= en_out_d;
      init_cnt_q  <= init_cnt_d;
      cap_pend_q  <= cap_pend_d;
      seeded_q    <= seeded_d;
      prev_q      <= prev_d;
      vel_q       <= vel_d;
      vel_valid_q <= vel_valid_d;
      homed_q     <= (state_d == StRun);
      busy_q      <= (state_d == StInit) || (state_d == StSeek) || (state_d == StSettle);
      fault_q     <= (state_d == StFault);
    end
  end

`ifdef ABZ_HOME_RETRY_EN
  always_ff @(posedge CLK) begin
    if (!ARSTN) retry_q <= '0;
    else        retry_q <= retry_d;
  end
`endif

  assign EN_INIT_OUT    = en_init_q;
  assign INIT_COUNT_OUT = init_cnt_q;
  assign EN_OUTPUT_OUT  = en_out_q;
  assign VEL_OUT        = vel_q;
  assign VEL_VALID      = vel_valid_q;
  assign HOMED          = homed_q;
  assign BUSY           = busy_q;
  assign FAULT_OUT      = fault_q;

endmodule

// File: tb/tb_abz_home_ctrl.sv
// Self-checking bench for abz_home_ctrl: homing, velocity table, timeout, abort and reset.
module tb_abz_home_ctrl;

  localparam int unsigned BL = 12;
  localparam int unsigned SP = 16;
  localparam int unsigned ST = 100;

  logic          CLK = 1'b0;
  logic          ARSTN = 1'b0;
  logic          START_IN = 1'b0;
  logic          ABORT_IN = 1'b0;
  logic          Z_IN = 1'b0;
  logic [BL-1:0] CFG_INIT_COUNT = '0;
  logic [BL-1:0] LATCHED_CNT_IN = '0;
  logic          EN_INIT_OUT, EN_OUTPUT_OUT, VEL_VALID, HOMED, BUSY, FAULT_OUT;
  logic [BL-1:0] INIT_COUNT_OUT, VEL_OUT;

  abz_home_ctrl #(
    .BIT_LENGTH   (BL),
    .TMO_WIDTH    (24),
    .SEEK_TIMEOUT (24'd100),
    .SETTLE_CYCLES(6),
    .SAMPLE_PERIOD(SP),
    .MAX_RETRY    (3)
  ) dut (
    .CLK           (CLK),
    .ARSTN         (ARSTN),
    .START_IN      (START_IN),
    .ABORT_IN      (ABORT_IN),
    .Z_IN          (Z_IN),
    .CFG_INIT_COUNT(CFG_INIT_COUNT),
    .LATCHED_CNT_IN(LATCHED_CNT_IN),
    .EN_INIT_OUT   (EN_INIT_OUT),
    .INIT_COUNT_OUT(INIT_COUNT_OUT),
    .EN_OUTPUT_OUT (EN_OUTPUT_OUT),
    .VEL_OUT       (VEL_OUT),
    .VEL_VALID     (VEL_VALID),
    .HOMED         (HOMED),
    .BUSY          (BUSY),
    .FAULT_OUT     (FAULT_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [BL-1:0] latched;
    logic          exp_valid;
    logic [BL-1:0] exp_vel;
  } vel_vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  logic [BL-1:0] exp_q[$];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] status();
    return {26'd0, EN_INIT_OUT, EN_OUTPUT_OUT, VEL_VALID, HOMED, BUSY, FAULT_OUT};
  endfunction

  // Count cycles until EN_INIT_OUT drops; entered right after the INIT edge.
  task automatic count_init(output int n);
    n = 0;
    while (EN_INIT_OUT && n < 10) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vel_vec_t vecs[6];
    int n;
    int pulses;
    int exp_pulses;
    logic prev_init;

    vecs[0] = '{latched: 12'd10,   exp_valid: 1'b0, exp_vel: 12'h000};
    vecs[1] = '{latched: 12'd25,   exp_valid: 1'b1, exp_vel: 12'd15};
    vecs[2] = '{latched: 12'd20,   exp_valid: 1'b1, exp_vel: 12'hFFB};
    vecs[3] = '{latched: 12'd4094, exp_valid: 1'b1, exp_vel: 12'hFEA};
    vecs[4] = '{latched: 12'd2,    exp_valid: 1'b1, exp_vel: 12'd4};
    vecs[5] = '{latched: 12'd4094, exp_valid: 1'b1, exp_vel: 12'hFFC};

    // Reset
    tick(); tick();
    check("reset_status", status(), 32'd0);
    check("reset_vel", {20'd0, VEL_OUT}, 32'd0);
    check("reset_init_count", {20'd0, INIT_COUNT_OUT}, 32'd0);
    ARSTN = 1'b1;
    tick();

    // Homing start
    CFG_INIT_COUNT = 12'h100;
    START_IN = 1'b1;
    tick();
    check("init_count_capture", {20'd0, INIT_COUNT_OUT}, 32'h100);
    check("init_busy", {31'd0, BUSY}, 32'd1);
    count_init(n);
    check("init_pulse_len", n, 2);
    check("seek_busy", {31'd0, BUSY}, 32'd1);

    // Z edge 50 cycles into SEEK
    repeat (49) tick();
    check("seek_not_fault", {31'd0, FAULT_OUT}, 32'd0);
    Z_IN = 1'b1;
    n = 0;
    while (!HOMED && n < 30) begin
      tick();
      n++;
    end
    check("z_to_homed_cycles", n, 9);
    check("run_status", status(), 32'b000100);

    // RUN: strobe period and velocity table via scoreboard
    n = 0;
    while (!EN_OUTPUT_OUT && n < 40) begin
      tick();
      n++;
    end
    check("first_strobe_delay", n, SP);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        n = 3;
        while (!EN_OUTPUT_OUT && n < 40) begin
          tick();
          n++;
        end
        check("strobe_period", n, SP);
      end
      // Junk outside the capture cycle catches a mistimed sample.
      LATCHED_CNT_IN = 12'h5A5;
      if (vecs[i].exp_valid) exp_q.push_back(vecs[i].exp_vel);
      tick();
      check("strobe_one_cycle", {31'd0, EN_OUTPUT_OUT}, 32'd0);
      check("valid_early", {31'd0, VEL_VALID}, 32'd0);
      LATCHED_CNT_IN = vecs[i].latched;
      tick();
      LATCHED_CNT_IN = 12'h3C3;
      check("vel_valid", {31'd0, VEL_VALID}, {31'd0, vecs[i].exp_valid});
      if (VEL_VALID) begin
        if (exp_q.size() == 0) begin
          check("vel_unexpected", {31'd0, VEL_VALID}, 32'd0);
        end else begin
          check("vel_value", {20'd0, VEL_OUT}, {20'd0, exp_q.pop_front()});
        end
      end
      tick();
      check("valid_one_cycle", {31'd0, VEL_VALID}, 32'd0);
    end
    check("scoreboard_drained", exp_q.size(), 0);
    Z_IN = 1'b0;

    // ABORT and START rise in the same RUN cycle
    START_IN = 1'b0;
    tick();
    ABORT_IN = 1'b1;
    START_IN = 1'b1;
    tick();
    check("abort_status", status(), 32'd0);
    check("abort_vel_cleared", {20'd0, VEL_OUT}, 32'd0);
    ABORT_IN = 1'b0;
    tick();
    check("idle_after_abort", status(), 32'd0);

    // Seek timeout (with optional retries)
    START_IN = 1'b0;
    tick();
    CFG_INIT_COUNT = 12'h2AB;
    START_IN = 1'b1;
    tick();
    check("init_count_recapture", {20'd0, INIT_COUNT_OUT}, 32'h2AB);
    count_init(n);
    check("init_pulse_len2", n, 2);
    n = 0;
    while (!FAULT_OUT && !EN_INIT_OUT && n < 300) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, ST);
`ifdef ABZ_HOME_RETRY_EN
    exp_pulses = 3;
`else
    exp_pulses = 1;
`endif
    pulses = 1;
    prev_init = 1'b0;
    n = 0;
    while (!FAULT_OUT && n < 1000) begin
      if (EN_INIT_OUT && !prev_init) pulses++;
      prev_init = EN_INIT_OUT;
      tick();
      n++;
    end
    check("init_pulse_count", pulses, exp_pulses);
    check("fault_status", status(), 32'b000001);
    tick();
    check("fault_holds", status(), 32'b000001);

    // Exit FAULT via START, then reset mid-SEEK
    START_IN = 1'b0;
    tick();
    START_IN = 1'b1;
    tick();
    check("fault_exit_init", status(), 32'b100010);
    repeat (4) tick();
    check("midseek_busy", status(), 32'b000010);
    ARSTN = 1'b0;
    tick();
    check("midseek_reset_status", status(), 32'd0);
    check("midseek_reset_count", {20'd0, INIT_COUNT_OUT}, 32'd0);
    ARSTN = 1'b1;
    START_IN = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
